// File: rtl/parser_input_arbiter_pkg.sv
// rtl/parser_input_arbiter_pkg.sv - shared defaults and state encoding for the parser input arbiter
package parser_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int MAX_BEATS_DEF = 16384;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/parser_input_arbiter_if.sv
// rtl/parser_input_arbiter_if.sv - multi-source beat bus in front of the parser input
interface parser_input_arbiter_if #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = parser_pkg::DATA_W_DEF
);

    logic [N_SRC*DATA_W-1:0] dataIn;
    logic [N_SRC-1:0]        dataIn_val;
    logic [N_SRC-1:0]        dataIn_last;
    logic [N_SRC-1:0]        dataIn_ready;
    logic [DATA_W-1:0]       dataOut;
    logic                    dataOut_val;
    logic                    dataOut_last;
    logic                    dataOut_ready;

    // master: the sources plus the parser; slave: the arbiter between them
    modport master (
        output dataIn, dataIn_val, dataIn_last, dataOut_ready,
        input  dataIn_ready, dataOut, dataOut_val, dataOut_last
    );

    modport slave (
        input  dataIn, dataIn_val, dataIn_last, dataOut_ready,
        output dataIn_ready, dataOut, dataOut_val, dataOut_last
    );

endinterface

// File: rtl/parser_input_arbiter_rr_pick.sv
// rtl/parser_input_arbiter_rr_pick.sv - rotating priority encoder starting just after the last grant
module rr_pick #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0]         req,
    input  logic [$clog2(N_SRC)-1:0] lastGrant,
    output logic [$clog2(N_SRC)-1:0] winner,
    output logic                     anyReq
);

    localparam int ID_W = $clog2(N_SRC);
    localparam logic [ID_W:0] NSRC = (ID_W+1)'(N_SRC);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // scan farthest offset first so the nearest requester after lastGrant wins
    always_comb begin
        winner = '0;
        anyReq = |req;
        sum    = '0;
        idx    = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            sum = {1'b0, lastGrant} + (ID_W+1)'(k);
            if (sum >= NSRC) begin
                sum = sum - NSRC;
            end
            idx = sum[ID_W-1:0];
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/parser_input_arbiter.sv
// rtl/parser_input_arbiter.sv - packet-atomic round-robin arbiter with max-length truncation
module parser_input_arbiter
    import parser_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic                     clk,
    input  logic                     reset_b,
    parser_input_arbiter_if.slave    bus,
    output logic [$clog2(N_SRC)-1:0] grant_id,
    output logic                     busy,
    output logic                     trunc_err
);

    localparam int ID_W  = $clog2(N_SRC);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    arb_state_t        state;
    arb_state_t        stateNext;
    logic [ID_W-1:0]   lastGrant;
    logic [ID_W-1:0]   winner;
    logic              anyReq;
    logic [CNT_W-1:0]  beatCnt;
    logic              truncSet;
    logic              atMax;
    logic              passXfer;
    logic [DATA_W-1:0] srcData [N_SRC];
    logic [DATA_W-1:0] selData;
    logic              selVal;
    logic              selLast;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign srcData[i] = bus.dataIn[i*DATA_W +: DATA_W];
    end

    assign selData  = srcData[grant_id];
    assign selVal   = bus.dataIn_val[grant_id];
    assign selLast  = bus.dataIn_last[grant_id];
    assign atMax    = (beatCnt == LAST_CNT);
    assign passXfer = (state == PASS) && selVal && bus.dataOut_ready;
    assign busy     = (state != IDLE);

    rr_pick #(
        .N_SRC (N_SRC)
    ) u_pick (
        .req       (bus.dataIn_val),
        .lastGrant (lastGrant),
        .winner    (winner),
        .anyReq    (anyReq)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext        = state;
        truncSet         = 1'b0;
        bus.dataOut      = '0;
        bus.dataOut_val  = 1'b0;
        bus.dataOut_last = 1'b0;
        bus.dataIn_ready = '0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNext = PASS;
                end
            end
            PASS: begin
                bus.dataOut                = selData;
                bus.dataOut_val            = selVal;
                bus.dataOut_last           = selLast | atMax;
                bus.dataIn_ready[grant_id] = bus.dataOut_ready;
                if (passXfer) begin
                    if (selLast) begin
                        stateNext = IDLE;
                    end else if (atMax) begin
                        stateNext = DRAIN;
                        truncSet  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // remainder of an overlong packet is swallowed without reaching the parser
                bus.dataIn_ready[grant_id] = 1'b1;
                if (selVal && selLast) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            lastGrant <= ID_W'(N_SRC - 1);
            grant_id  <= '0;
            beatCnt   <= '0;
            trunc_err <= 1'b0;
        end else begin
            trunc_err <= truncSet;
            if ((state == IDLE) && anyReq) begin
                grant_id  <= winner;
                lastGrant <= winner;
                beatCnt   <= '0;
            end else if (passXfer) begin
                beatCnt <= beatCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_parser_input_arbiter.sv
// tb/tb_parser_input_arbiter.sv - scoreboard bench for the parser input arbiter
module tb_parser_input_arbiter;

    typedef struct packed {
        logic [1:0]  src;
        logic        last;
        logic [31:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstA;
    logic       rstB;
    logic [1:0] gidA, gidB;
    logic       busyA, busyB;
    logic       truncA, truncB;

    parser_input_arbiter_if #(.N_SRC(4), .DATA_W(32)) ifA ();
    parser_input_arbiter_if #(.N_SRC(4), .DATA_W(32)) ifB ();

    parser_input_arbiter #(.N_SRC(4), .DATA_W(32), .MAX_BEATS(16384)) dutA (
        .clk       (clk),
        .reset_b   (rstA),
        .bus       (ifA),
        .grant_id  (gidA),
        .busy      (busyA),
        .trunc_err (truncA)
    );

    parser_input_arbiter #(.N_SRC(4), .DATA_W(32), .MAX_BEATS(4)) dutB (
        .clk       (clk),
        .reset_b   (rstB),
        .bus       (ifB),
        .grant_id  (gidB),
        .busy      (busyB),
        .trunc_err (truncB)
    );

    always #5 clk = ~clk;

    exp_t        sb [2][$];
    logic [32:0] srcQ [8][$];
    logic [3:0]  xferPend [2];
    int          idleReq [2];
    int          truncHigh [2];
    int          outCnt [2];
    logic        holdValid [2];
    logic [31:0] heldData [2];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monStep(input bit d, input logic rstb, input logic val, input logic rdy,
                           input logic last, input logic [31:0] data, input logic [1:0] gid,
                           input logic busy, input logic [3:0] inVal, input logic [3:0] inRdy,
                           input logic trunc);
        exp_t       e;
        logic [3:0] mask;
        xferPend[d] = inVal & inRdy;
        if (!rstb) begin
            holdValid[d] = 1'b0;
        end else begin
            mask = busy ? (4'b0001 << gid) : 4'b0000;
            chk("other_ready", 64'(inRdy & ~mask), 64'(0));
            if (holdValid[d]) chk("stall_hold", {31'd0, val, data}, {31'd0, 1'b1, heldData[d]});
            holdValid[d] = val && !rdy;
            heldData[d]  = data;
            if (!busy && (|inVal)) idleReq[d]++;
            if (trunc) truncHigh[d]++;
            if (val && rdy) begin
                outCnt[d]++;
                checks++;
                assert (sb[d].size() > 0) else begin
                    errors++;
                    $error("FAIL extra_beat observed=%0h expected=none", data);
                end
                if (sb[d].size() > 0) begin
                    e = sb[d].pop_front();
                    chk("beat_data", 64'(data), 64'(e.data));
                    chk("beat_last", 64'(last), 64'(e.last));
                    chk("beat_src", 64'(gid), 64'(e.src));
                end
            end
        end
    endtask

    always @(negedge clk) begin
        monStep(1'b0, rstA, ifA.dataOut_val, ifA.dataOut_ready, ifA.dataOut_last, ifA.dataOut,
                gidA, busyA, ifA.dataIn_val, ifA.dataIn_ready, truncA);
        monStep(1'b1, rstB, ifB.dataOut_val, ifB.dataOut_ready, ifB.dataOut_last, ifB.dataOut,
                gidB, busyB, ifB.dataIn_val, ifB.dataIn_ready, truncB);
    end

    // sources hold each beat until it is accepted, then present the next queued one
    always @(posedge clk) begin : drv
        logic [2:0]  qi;
        logic [31:0] dd [2][4];
        logic [3:0]  vv [2];
        logic [3:0]  ll [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 4; s++) begin
                qi = {d[0], s[1:0]};
                if (xferPend[d[0]][s[1:0]] && srcQ[qi].size() > 0) void'(srcQ[qi].pop_front());
                if (srcQ[qi].size() > 0) begin
                    dd[d[0]][s[1:0]] = srcQ[qi][0][31:0];
                    vv[d[0]][s[1:0]] = 1'b1;
                    ll[d[0]][s[1:0]] = srcQ[qi][0][32];
                end else begin
                    dd[d[0]][s[1:0]] = '0;
                    vv[d[0]][s[1:0]] = 1'b0;
                    ll[d[0]][s[1:0]] = 1'b0;
                end
            end
        end
        ifA.dataIn      = {dd[0][3], dd[0][2], dd[0][1], dd[0][0]};
        ifA.dataIn_val  = vv[0];
        ifA.dataIn_last = ll[0];
        ifB.dataIn      = {dd[1][3], dd[1][2], dd[1][1], dd[1][0]};
        ifB.dataIn_val  = vv[1];
        ifB.dataIn_last = ll[1];
    end

    task automatic srcPkt(input bit d, input logic [1:0] s, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) srcQ[{d, s}].push_back({(i == n - 1), base + 32'(i)});
    endtask

    task automatic expPkt(input bit d, input logic [1:0] s, input int n, input int fwd,
                          input logic [31:0] base);
        exp_t e;
        for (int i = 0; i < fwd; i++) begin
            e.src  = s;
            e.last = (i == n - 1) || (i == fwd - 1);
            e.data = base + 32'(i);
            sb[d].push_back(e);
        end
    endtask

    task automatic waitDone(input bit d, input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge clk);
            #2;
            done = (sb[d].size() == 0) && (srcQ[{d, 2'd0}].size() == 0) &&
                   (srcQ[{d, 2'd1}].size() == 0) && (srcQ[{d, 2'd2}].size() == 0) &&
                   (srcQ[{d, 2'd3}].size() == 0) && !(d ? busyB : busyA);
        end
        chk({tag, "_done"}, 64'(done), 64'(1));
    endtask

    task automatic chkResetA(input string tag);
        chk({tag, "_val"}, 64'(ifA.dataOut_val), 64'(0));
        chk({tag, "_last"}, 64'(ifA.dataOut_last), 64'(0));
        chk({tag, "_data"}, 64'(ifA.dataOut), 64'(0));
        chk({tag, "_ready"}, 64'(ifA.dataIn_ready), 64'(0));
        chk({tag, "_busy"}, 64'(busyA), 64'(0));
        chk({tag, "_gid"}, 64'(gidA), 64'(0));
        chk({tag, "_trunc"}, 64'(truncA), 64'(0));
    endtask

    initial begin
        int   base0, c0;
        bit   hit;
        logic [31:0] t1Data [5];
        logic [3:0]  pat;
        exp_t e;

        for (int d = 0; d < 2; d++) begin
            xferPend[d] = '0;  idleReq[d] = 0;  truncHigh[d] = 0;
            outCnt[d] = 0;     holdValid[d] = 1'b0;  heldData[d] = '0;
        end
        rstA = 1'b0;
        rstB = 1'b0;
        ifA.dataOut_ready = 1'b1;
        ifB.dataOut_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chkResetA("rstA");
        chk("rstB_val", 64'(ifB.dataOut_val), 64'(0));
        chk("rstB_ready", 64'(ifB.dataIn_ready), 64'(0));
        chk("rstB_busy", 64'(busyB), 64'(0));
        chk("rstB_trunc", 64'(truncB), 64'(0));
        rstA = 1'b1;
        rstB = 1'b1;

        // 5-beat packet from src0 passes unchanged
        @(posedge clk);
        #2;
        t1Data[0] = 32'h1400_0C00;  t1Data[1] = 32'h0100_0000;
        t1Data[2] = 32'h0123_4562;  t1Data[3] = 32'h0123_4563;  t1Data[4] = 32'h0123_4564;
        for (int i = 0; i < 5; i++) begin
            srcQ[0].push_back({(i == 4), t1Data[i]});
            e.src = 2'd0;  e.last = (i == 4);  e.data = t1Data[i];
            sb[0].push_back(e);
        end
        waitDone(1'b0, "t1");

        // fresh reset, then src0 streams two packets against src2: rotation interleaves them
        rstA = 1'b0;
        @(posedge clk);
        #2;
        rstA = 1'b1;
        base0 = idleReq[0];
        srcPkt(1'b0, 2'd0, 3, 32'h2000_0000);
        srcPkt(1'b0, 2'd0, 3, 32'h2100_0000);
        srcPkt(1'b0, 2'd2, 3, 32'h2200_0000);
        srcPkt(1'b0, 2'd2, 3, 32'h2300_0000);
        expPkt(1'b0, 2'd0, 3, 3, 32'h2000_0000);
        expPkt(1'b0, 2'd2, 3, 3, 32'h2200_0000);
        expPkt(1'b0, 2'd0, 3, 3, 32'h2100_0000);
        expPkt(1'b0, 2'd2, 3, 3, 32'h2300_0000);
        waitDone(1'b0, "t2");
        chk("t2_bubbles", 64'(idleReq[0] - base0), 64'(4));

        // parser backpressure 1,0,0,1 during a 4-beat src1 packet
        ifA.dataOut_ready = 1'b0;
        c0 = outCnt[0];
        srcPkt(1'b0, 2'd1, 4, 32'h3000_0000);
        expPkt(1'b0, 2'd1, 4, 4, 32'h3000_0000);
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(posedge clk);
            #2;
            hit = busyA;
        end
        chk("t3_grant", 64'(hit), 64'(1));
        pat = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            ifA.dataOut_ready = pat[i[1:0]];
            @(posedge clk);
            #2;
        end
        ifA.dataOut_ready = 1'b1;
        waitDone(1'b0, "t3");
        chk("t3_xfers", 64'(outCnt[0] - c0), 64'(4));

        // reset during beat 2 of a 6-beat src0 packet
        c0 = outCnt[0];
        srcPkt(1'b0, 2'd0, 6, 32'h6000_0000);
        expPkt(1'b0, 2'd0, 6, 6, 32'h6000_0000);
        hit = 1'b0;
        for (int n = 0; n < 40 && !hit; n++) begin
            @(posedge clk);
            #2;
            hit = (outCnt[0] - c0) >= 2;
        end
        chk("t6_reach_beat2", 64'(hit), 64'(1));
        rstA = 1'b0;
        #1;
        chkResetA("t6_rst");
        for (int s = 0; s < 4; s++) srcQ[s].delete();
        sb[0].delete();
        srcPkt(1'b0, 2'd1, 3, 32'h6100_0000);
        expPkt(1'b0, 2'd1, 3, 3, 32'h6100_0000);
        @(posedge clk);
        #2;
        rstA = 1'b1;
        srcPkt(1'b0, 2'd0, 6, 32'h6000_0000);
        expPkt(1'b0, 2'd0, 6, 6, 32'h6000_0000);
        waitDone(1'b0, "t6");

        // MAX_BEATS=4: 7-beat src3 packet is cut after beat 4 and drained
        base0 = truncHigh[1];
        srcPkt(1'b1, 2'd3, 7, 32'h4000_0000);
        expPkt(1'b1, 2'd3, 7, 4, 32'h4000_0000);
        waitDone(1'b1, "t4");
        chk("t4_trunc_pulse", 64'(truncHigh[1] - base0), 64'(1));

        // MAX_BEATS=4: exactly 4 beats with last on beat 4 ends normally
        base0 = truncHigh[1];
        srcPkt(1'b1, 2'd1, 4, 32'h5000_0000);
        expPkt(1'b1, 2'd1, 4, 4, 32'h5000_0000);
        waitDone(1'b1, "t5");
        chk("t5_no_trunc", 64'(truncHigh[1] - base0), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
